// File: rtl/stream_downsizer.sv
// stream_downsizer
//   Width-reducing valid/ready stage. Takes one wide beat of RATIO narrow
//   words and replays the first in_len_i words, least-significant word first,
//   as narrow beats. The packet-end marker rides on the final emitted word.
//
//   state | meaning
//   IDLE  | holding register empty, in_ready_o = 1, outputs zero
//   EMIT  | presenting word idx of the held beat on the narrow side
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   in_valid_i    wide beat valid
//   in_ready_o    wide beat ready (combinational from out_ready_i)
//   in_data_i     wide beat, word k at [k*OUT_WIDTH +: OUT_WIDTH]
//   in_len_i      number of valid words from word 0 (clamped to RATIO, 0 = drop)
//   in_last_i     beat ends a packet
//   out_valid_o   narrow word valid (registered)
//   out_ready_i   downstream ready
//   out_data_o    narrow word, zero when not valid (registered)
//   out_last_o    final word of a last beat, zero when not valid (registered)
module stream_downsizer #(
  parameter int OUT_WIDTH = 8,
  parameter int RATIO     = 4,
  parameter int LEN_WIDTH = $clog2(RATIO + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [OUT_WIDTH*RATIO-1:0] in_data_i,
  input  logic [LEN_WIDTH-1:0]       in_len_i,
  input  logic                       in_last_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [OUT_WIDTH-1:0]       out_data_o,
  output logic                       out_last_o
);

  localparam int IDX_W = $clog2(RATIO);
  localparam logic [LEN_WIDTH-1:0] RATIO_L = LEN_WIDTH'(RATIO);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                     state_q;
  logic [OUT_WIDTH*RATIO-1:0] hold_q;
  logic [IDX_W-1:0]           idx_q;
  logic [IDX_W-1:0]           len_m1_q;   // stored length minus one (index of final word)
  logic                       last_q;

  logic [OUT_WIDTH-1:0]       hold_words [RATIO];
  logic [LEN_WIDTH-1:0]       len_c;
  logic [IDX_W-1:0]           idx_nxt;
  logic                       is_final;
  logic                       accept;
  logic                       out_hs;

  always_comb begin
    for (int k = 0; k < RATIO; k++) begin
      hold_words[k] = hold_q[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign len_c    = (in_len_i > RATIO_L) ? RATIO_L : in_len_i;
  assign idx_nxt  = idx_q + IDX_W'(1);
  assign is_final = (state_q == EMIT) && (idx_q == len_m1_q);
  assign out_hs   = (state_q == EMIT) && out_ready_i;

  // Only combinational path out_ready_i -> in_ready_o; upstream skid buffer
  // registers its own ready so this does not chain further.
  assign in_ready_o = (state_q == IDLE) || (out_ready_i && is_final);
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      idx_q       <= '0;
      len_m1_q    <= '0;
      last_q      <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
    end else if (accept) begin
      // Accept covers both the idle load and the load that overlaps the
      // final-word handshake of the previous beat.
      if (len_c != '0) begin
        state_q     <= EMIT;
        hold_q      <= in_data_i;
        idx_q       <= '0;
        len_m1_q    <= IDX_W'(len_c - LEN_WIDTH'(1));
        last_q      <= in_last_i;
        out_valid_o <= 1'b1;
        out_data_o  <= in_data_i[OUT_WIDTH-1:0];
        out_last_o  <= in_last_i && (len_c == LEN_WIDTH'(1));
      end else begin
        state_q     <= IDLE;
        idx_q       <= '0;
        out_valid_o <= 1'b0;
        out_data_o  <= '0;
        out_last_o  <= 1'b0;
      end
    end else if (out_hs) begin
      if (is_final) begin
        state_q     <= IDLE;
        idx_q       <= '0;
        out_valid_o <= 1'b0;
        out_data_o  <= '0;
        out_last_o  <= 1'b0;
      end else begin
        idx_q       <= idx_nxt;
        out_data_o  <= hold_words[idx_nxt];
        out_last_o  <= last_q && (idx_nxt == len_m1_q);
      end
    end
  end

endmodule

// File: tb/tb_stream_downsizer.sv
module tb_stream_downsizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic [2:0]  in_len_i;
  logic        in_last_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  out_data_o;
  logic        out_last_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_downsizer #(.OUT_WIDTH(8), .RATIO(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_len_i(in_len_i), .in_last_i(in_last_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] data;
    logic [2:0]  len;
    logic        last;
    logic        ordy;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
    logic        er;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } word_t;

  vec_t  vecs[$];
  word_t mq[$];

  task automatic add(input logic r, input logic iv, input logic [31:0] d,
                     input logic [2:0] len, input logic lst, input logic ordy,
                     input logic ev, input logic [7:0] ed, input logic el,
                     input logic er);
    vec_t v;
    v.rst = r; v.iv = iv; v.data = d; v.len = len; v.last = lst; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.el = el; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [31:0] d,
                       input logic [2:0] len, input logic lst, input logic ordy);
    rst = r; in_valid_i = iv; in_data_i = d; in_len_i = len;
    in_last_i = lst; out_ready_i = ordy;
  endtask

  task automatic check_outs(input int idx, input logic ev, input logic [7:0] ed,
                            input logic el, input logic er);
    check("out_valid", idx, {31'd0, out_valid_o}, {31'd0, ev});
    check("out_data",  idx, {24'd0, out_data_o},  {24'd0, ed});
    check("out_last",  idx, {31'd0, out_last_o},  {31'd0, el});
    check("in_ready",  idx, {31'd0, in_ready_o},  {31'd0, er});
  endtask

  // Reference: a queue of the narrow words still owed downstream.
  task automatic model_step(input logic r, input logic iv, input logic [31:0] d,
                            input logic [2:0] len, input logic lst,
                            input logic ordy, input logic rdy);
    int l;
    word_t w;
    if (r) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && ordy) void'(mq.pop_front());
      if (iv && rdy) begin
        l = (len > 3'd4) ? 4 : int'(len);
        for (int k = 0; k < l; k++) begin
          w.d = d[k*8 +: 8];
          w.l = lst && (k == l - 1);
          mq.push_back(w);
        end
      end
    end
  endtask

  initial begin
    logic        r, iv, lst, ordy, ev, el, er;
    logic [31:0] d;
    logic [2:0]  len;
    logic [7:0]  ed;

    // reset checks
    add(1,0,32'h0,0,0,1,            0,8'h00,0,1);
    add(0,0,32'h0,0,0,1,            0,8'h00,0,1);
    // full beat
    add(0,1,32'hDDCCBBAA,4,1,1,     0,8'h00,0,1);
    add(0,0,32'h0,0,0,1,            1,8'hAA,0,0);
    add(0,0,32'h0,0,0,1,            1,8'hBB,0,0);
    add(0,0,32'h0,0,0,1,            1,8'hCC,0,0);
    add(0,0,32'h0,0,0,1,            1,8'hDD,1,1);
    add(0,0,32'h0,0,0,1,            0,8'h00,0,1);
    // back-to-back with in_valid held
    add(0,1,32'h44332211,4,0,1,     0,8'h00,0,1);
    add(0,1,32'h88776655,2,1,1,     1,8'h11,0,0);
    add(0,1,32'h88776655,2,1,1,     1,8'h22,0,0);
    add(0,1,32'h88776655,2,1,1,     1,8'h33,0,0);
    add(0,1,32'h88776655,2,1,1,     1,8'h44,0,1);
    add(0,0,32'h0,0,0,1,            1,8'h55,0,0);
    add(0,0,32'h0,0,0,1,            1,8'h66,1,1);
    add(0,0,32'h0,0,0,1,            0,8'h00,0,1);
    // backpressure 1,0,0,1,1,0,1
    add(0,1,32'hDDCCBBAA,4,1,1,     0,8'h00,0,1);
    add(0,0,32'h0,0,0,1,            1,8'hAA,0,0);
    add(0,0,32'h0,0,0,0,            1,8'hBB,0,0);
    add(0,0,32'h0,0,0,0,            1,8'hBB,0,0);
    add(0,0,32'h0,0,0,1,            1,8'hBB,0,0);
    add(0,0,32'h0,0,0,1,            1,8'hCC,0,0);
    add(0,0,32'h0,0,0,0,            1,8'hDD,1,0);
    add(0,0,32'h0,0,0,1,            1,8'hDD,1,1);
    add(0,0,32'h0,0,0,1,            0,8'h00,0,1);
    // len 0 dropped, len 7 clamped
    add(0,1,32'h12345678,0,1,1,     0,8'h00,0,1);
    add(0,1,32'h0D0C0B0A,7,0,1,     0,8'h00,0,1);
    add(0,0,32'h0,0,0,1,            1,8'h0A,0,0);
    add(0,0,32'h0,0,0,1,            1,8'h0B,0,0);
    add(0,0,32'h0,0,0,1,            1,8'h0C,0,0);
    add(0,0,32'h0,0,0,1,            1,8'h0D,0,1);
    add(0,0,32'h0,0,0,1,            0,8'h00,0,1);
    // reset mid-beat after BB, then single-word last beat
    add(0,1,32'hDDCCBBAA,4,1,1,     0,8'h00,0,1);
    add(0,0,32'h0,0,0,1,            1,8'hAA,0,0);
    add(1,0,32'h0,0,0,1,            1,8'hBB,0,0);
    add(0,0,32'h0,0,0,1,            0,8'h00,0,1);
    add(0,1,32'h000000EE,1,1,1,     0,8'h00,0,1);
    add(0,0,32'h0,0,0,1,            1,8'hEE,1,1);
    add(0,0,32'h0,0,0,1,            0,8'h00,0,1);

    // initial reset so the first row sees defined register values
    drive(1,0,32'h0,0,0,1);
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].data, vecs[i].len,
            vecs[i].last, vecs[i].ordy);
      @(negedge clk);
      check_outs(i, vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].er);
      @(posedge clk);
      #1;
    end

    // randomized traffic against the word-queue model
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      r    = ($urandom_range(0, 199) == 0);
      iv   = $urandom_range(0, 3) != 0;
      d    = $urandom;
      len  = 3'($urandom_range(0, 7));
      lst  = 1'($urandom_range(0, 1));
      ordy = $urandom_range(0, 3) != 0;
      drive(r, iv, d, len, lst, ordy);
      ev = (mq.size() > 0);
      ed = ev ? mq[0].d : 8'h00;
      el = ev ? mq[0].l : 1'b0;
      er = (mq.size() == 0) || (ordy && mq.size() == 1);
      @(negedge clk);
      check_outs(1000 + c, ev, ed, el, er);
      model_step(r, iv, d, len, lst, ordy, er);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
